// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings common to uart_tx/uart_rx and
// the bit-time counter width helper.
package uart_pkg;

   // 3-bit encodings shared with uart_tx; WAIT_HIGH is used by the receiver only
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START_BIT = 3'd1,
      DATA_BITS = 3'd2,
      STOP_BIT  = 3'd3,
      WAIT_HIGH = 3'd4
   } uart_state_e;

   // Width of the per-bit clock counter; one spare bit above the bit-time range
   function automatic int unsigned uart_cnt_width(input int unsigned clks_per_bit);
      return $clog2(clks_per_bit) + 1;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side output bundle of the UART receiver.
// master: the receiver driving the bundle; slave: the consuming logic.
interface uart_rx_if;
   logic       o_RX_DV;
   logic [7:0] o_RX_Byte;
   logic       o_RX_Active;
   logic       o_RX_Frame_Err;

   modport master (
      output o_RX_DV,
      output o_RX_Byte,
      output o_RX_Active,
      output o_RX_Frame_Err
   );

   modport slave (
      input o_RX_DV,
      input o_RX_Byte,
      input o_RX_Active,
      input o_RX_Frame_Err
   );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for a single asynchronous input. Both flops reset
// to 1 so an idle-high line never shows a false falling edge after reset.
module uart_rx_sync (
   input  logic i_Clock,
   input  logic i_Rst_n,
   input  logic i_async,
   output logic o_sync
);

   logic meta_d, meta_q;
   logic sync_d, sync_q;

   // next values: shift the async input through the two stages
   always_comb begin
      meta_d = i_async;
      sync_d = meta_q;
   end

   // synchronizer flops, preset high on reset
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign o_sync = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, mid-bit sampling of the synchronized line.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge on rx_s
// START_BIT | counting to half a bit to confirm the start bit
// DATA_BITS | sampling 8 data bits, one per bit time, at mid-bit
// STOP_BIT  | sampling the stop bit; good -> byte strobe, low -> error
// WAIT_HIGH | after a framing error, hold until the line returns high
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 217
) (
   input  logic      i_Clock,
   input  logic      i_Rst_n,
   input  logic      i_RX_Serial,
   uart_rx_if.master rx_if
);

   localparam int unsigned CW = uart_cnt_width(CLKS_PER_BIT);
   localparam int unsigned H  = (CLKS_PER_BIT - 1) / 2;
   localparam logic [CW-1:0] HALF_CNT = CW'(H);
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

   logic rx_s;

   uart_rx_sync u_sync (
      .i_Clock (i_Clock),
      .i_Rst_n (i_Rst_n),
      .i_async (i_RX_Serial),
      .o_sync  (rx_s)
   );

   uart_state_e   state_d, state_q;
   logic [CW-1:0] cnt_d, cnt_q;
   logic [2:0]    idx_d, idx_q;
   logic [7:0]    shift_d, shift_q;
   logic [7:0]    byte_d, byte_q;
   logic          dv_d, dv_q;
   logic          err_d, err_q;
   logic          active_d, active_q;

   // next-state and output logic; strobes default low so they last one cycle
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      byte_d   = byte_q;
      dv_d     = 1'b0;
      err_d    = 1'b0;
      active_d = active_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (!rx_s) begin
               state_d  = START_BIT;
               active_d = 1'b1;
            end
         end
         START_BIT: begin
            if (cnt_q == HALF_CNT) begin
               cnt_d = '0;
               if (!rx_s) begin
                  state_d = DATA_BITS;
               end else begin
                  // line went back high before mid start bit: a glitch
                  state_d  = IDLE;
                  active_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DATA_BITS: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_s;
               if (idx_q == 3'd7) begin
                  idx_d   = '0;
                  state_d = STOP_BIT;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         STOP_BIT: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d    = '0;
               active_d = 1'b0;
               if (rx_s) begin
                  byte_d  = shift_q;
                  dv_d    = 1'b1;
                  state_d = IDLE;
               end else begin
                  // a held-low line must not be re-read as further frames
                  err_d   = 1'b1;
                  state_d = WAIT_HIGH;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         WAIT_HIGH: begin
            cnt_d = '0;
            if (rx_s) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d  = IDLE;
            cnt_d    = '0;
            idx_d    = '0;
            active_d = 1'b0;
         end
      endcase
   end

   // state and registered outputs
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         byte_q   <= '0;
         dv_q     <= 1'b0;
         err_q    <= 1'b0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         byte_q   <= byte_d;
         dv_q     <= dv_d;
         err_q    <= err_d;
         active_q <= active_d;
      end
   end

   assign rx_if.o_RX_DV        = dv_q;
   assign rx_if.o_RX_Byte      = byte_q;
   assign rx_if.o_RX_Active    = active_q;
   assign rx_if.o_RX_Frame_Err = err_q;

endmodule
